// File: rtl/disp_bus_pkg.sv
// Shared types and defaults for the display bus arbiter: FSM state, display word, sizing defaults.
package disp_bus_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_DWELL = 1000;

    typedef logic [31:0] disp_word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } disp_state_e;

    // Successor of a requester index, wrapping at the number of requesters actually present.
    function automatic int wrap_inc(input int idx, input int n);
        int nxt;
        if (idx + 1 >= n) begin
            nxt = 0;
        end else begin
            nxt = idx + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first asserted request at or after ptr, wrapping at N_REQ.
module rr_picker
    import disp_bus_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] win,
    output logic             valid
);

    int   idx_s;
    logic found_s;

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        win     = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = int'(ptr) + k;
            if (idx_s >= N_REQ) begin
                idx_s = idx_s - N_REQ;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req[idx_s]) begin
                win[idx_s] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        valid = found_s;
    end

endmodule

// File: rtl/display_bus_arbiter.sv
// Round-robin arbiter sharing a seven-segment display among N_REQ requesters with a minimum dwell.
// Optional preemption by requester 0 is enabled with macro DISP_ARB_PREEMPT_EN.
module display_bus_arbiter
    import disp_bus_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    parameter  int DWELL = DEF_DWELL,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*32-1:0] wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [31:0]         disp_data,
    output logic [IW-1:0]       owner,
    output logic                busy
);

    localparam logic [15:0] CNT_LOAD = 16'(DWELL - 1);

    disp_state_e      state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    disp_word_t       disp_q, disp_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] pick_win_s;
    logic             pick_valid_s;
    int               pick_idx_s;
    int               win_idx_s;
    logic             grant_s;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .win   (pick_win_s),
        .valid (pick_valid_s)
    );

    // One-hot winner to index.
    always_comb begin
        pick_idx_s = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_win_s[i]) begin
                pick_idx_s = i;
            end else begin
                pick_idx_s = pick_idx_s;
            end
        end
    end

    // Next-state logic: grant from IDLE, count down the dwell in HOLD.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        gnt_d     = '0;
        disp_d    = disp_q;
        owner_d   = owner_q;
        grant_s   = 1'b0;
        win_idx_s = pick_idx_s;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    grant_s = 1'b1;
                end else begin
                    grant_s = 1'b0;
                end
            end
            ST_HOLD: begin
`ifdef DISP_ARB_PREEMPT_EN
                // Requester 0 may cut a foreign dwell short, but never its own.
                if (req[0] && (owner_q != '0)) begin
                    grant_s   = 1'b1;
                    win_idx_s = 0;
                end else if (cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
`else
                if (cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (grant_s) begin
            gnt_d[win_idx_s] = 1'b1;
            disp_d           = wdata[32*win_idx_s +: 32];
            owner_d          = IW'(win_idx_s);
            ptr_d            = IW'(wrap_inc(win_idx_s, N_REQ));
            cnt_d            = CNT_LOAD;
            state_d          = ST_HOLD;
        end else begin
            gnt_d = '0;
        end
        busy_d = (state_d == ST_HOLD);
    end

    // State and output registers with immediate clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            disp_q  <= 32'h0;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            disp_q  <= disp_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign disp_data = disp_q;
    assign owner     = owner_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_display_bus_arbiter.sv
// Randomized and directed bench for display_bus_arbiter (N_REQ=4, DWELL=4) against a dwell-time reference model.
module tb_display_bus_arbiter;

    localparam int N  = 4;
    localparam int DW = 4;

`ifdef DISP_ARB_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            clr;
    logic [N-1:0]    req;
    logic [N*32-1:0] wdata;
    logic [N-1:0]    gnt;
    logic [31:0]     disp_data;
    logic [1:0]      owner;
    logic            busy;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining dwell cycles instead of a counter/state pair.
    int          m_hold;
    int          m_ptr;
    logic [N-1:0] m_gnt;
    logic [31:0] m_disp;
    logic [1:0]  m_owner;

    display_bus_arbiter #(.N_REQ(N), .DWELL(DW)) dut (
        .clk       (clk),
        .clr       (clr),
        .req       (req),
        .wdata     (wdata),
        .gnt       (gnt),
        .disp_data (disp_data),
        .owner     (owner),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_hold  = 0;
        m_ptr   = 0;
        m_gnt   = '0;
        m_disp  = 32'h0;
        m_owner = 2'd0;
    endtask

    task automatic model_grant(input int w);
        m_gnt        = '0;
        m_gnt[w]     = 1'b1;
        m_disp       = wdata[32*w +: 32];
        m_owner      = 2'(w);
        m_ptr        = (w + 1) % N;
        m_hold       = DW;
    endtask

    task automatic model_edge();
        int w;
        m_gnt = '0;
        if (m_hold == 0) begin
            if (req != '0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
                model_grant(w);
            end
        end else if (PREEMPT && req[0] && m_owner != 2'd0) begin
            model_grant(0);
        end else begin
            m_hold = m_hold - 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        model_reset();
        #2;
        clr = 1'b1;
    endtask

    task automatic test_reset();
        clr   = 1'b0;
        req   = 4'b1111;
        wdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        model_reset();
        #1;
        total++;
        if ({gnt, disp_data, busy} !== {4'b0000, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_now gnt=%b disp=%h busy=%b expected 0000/0/0", gnt, disp_data, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({gnt, disp_data, busy, owner} !== {4'b0000, 32'h0, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL reset_held gnt=%b disp=%h busy=%b owner=%0d expected all zero", gnt, disp_data, busy, owner);
        end
        clr = 1'b1;
        tick();
        total++;
        if (gnt !== 4'b0001 || disp_data !== 32'h1111_1111) begin
            bad++;
            $display("FAIL reset_first_grant gnt=%b disp=%h expected 0001/11111111", gnt, disp_data);
        end
    endtask

    task automatic test_round_robin();
        int wins[$];
        int times[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < N; i++) wdata[32*i +: 32] = 32'h1111_1111 * (i + 1);
        for (int c = 1; c <= 21; c++) begin
            tick();
            total++;
            if ({gnt, owner, busy, disp_data} !== {m_gnt, m_owner, (m_hold > 0), m_disp}) begin
                bad++;
                $display("FAIL rr_cycle%0d gnt=%b owner=%0d busy=%b disp=%h expected %b/%0d/%b/%h",
                         c, gnt, owner, busy, disp_data, m_gnt, m_owner, (m_hold > 0), m_disp);
            end
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    wins.push_back(i);
                    times.push_back(c);
                end
            end
        end
        total++;
        if (wins.size() != 5) begin
            bad++;
            $display("FAIL rr_count grants=%0d expected 5", wins.size());
        end else begin
            for (int j = 0; j < 5; j++) begin
                total++;
                if (wins[j] != exp_order[j] || times[j] != 1 + 5 * j) begin
                    bad++;
                    $display("FAIL rr_order%0d winner=%0d at=%0d expected %0d at %0d",
                             j, wins[j], times[j], exp_order[j], 1 + 5 * j);
                end
            end
        end
    endtask

    task automatic test_single();
        int busy_cnt = 0;
        int regrant  = 0;
        do_reset();
        req = 4'b0100;
        wdata[32*2 +: 32] = 32'hF000_F000;
        tick();
        total++;
        if (gnt !== 4'b0100 || disp_data !== 32'hF000_F000 || owner !== 2'd2) begin
            bad++;
            $display("FAIL single_grant gnt=%b disp=%h owner=%0d expected 0100/f000f000/2", gnt, disp_data, owner);
        end
        if (busy) busy_cnt++;
        for (int c = 2; c <= 12 && regrant == 0; c++) begin
            tick();
            if (gnt === 4'b0100) regrant = c;
            else if (busy) busy_cnt++;
        end
        total++;
        if (busy_cnt != 4 || regrant != 6) begin
            bad++;
            $display("FAIL single_dwell busy_cycles=%0d regrant_at=%0d expected 4 and 6", busy_cnt, regrant);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b0001;
        wdata[31:0]  = 32'hABCD_0123;
        wdata[63:32] = 32'h5A5A_5A5A;
        tick();
        req = 4'b0000;
        for (int c = 2; c <= 10; c++) begin
            if (c == 3) req = 4'b0010;
            if (c == 5) req = 4'b0000;
            tick();
            total++;
            if (gnt !== 4'b0000 || disp_data !== 32'hABCD_0123 || gnt !== m_gnt) begin
                bad++;
                $display("FAIL withdraw_cycle%0d gnt=%b disp=%h expected 0000/abcd0123", c, gnt, disp_data);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        req = 4'b0100;
        wdata[32*2 +: 32] = 32'h5555_AAAA;
        wdata[31:0]       = 32'h0BAD_CAFE;
        tick();
        req = 4'b0000;
        tick();
        total++;
        if (busy !== 1'b1 || disp_data !== 32'h5555_AAAA) begin
            bad++;
            $display("FAIL midhold_pre busy=%b disp=%h expected 1/5555aaaa", busy, disp_data);
        end
        #2;
        clr = 1'b0;
        model_reset();
        #1;
        total++;
        if (busy !== 1'b0 || disp_data !== 32'h0 || gnt !== 4'b0000) begin
            bad++;
            $display("FAIL midhold_clear busy=%b disp=%h gnt=%b expected 0/0/0000", busy, disp_data, gnt);
        end
        clr = 1'b1;
        req = 4'b1111;
        tick();
        total++;
        if (gnt !== 4'b0001 || disp_data !== 32'h0BAD_CAFE) begin
            bad++;
            $display("FAIL midhold_restart gnt=%b disp=%h expected 0001/0badcafe", gnt, disp_data);
        end
    endtask

    task automatic test_preempt();
        logic [3:0] exp_gnt;
        do_reset();
        req = 4'b0100;
        wdata[31:0]       = 32'h0000_0C0C;
        wdata[32*2 +: 32] = 32'h2222_0000;
        tick();
        req = 4'b0001;
        tick();
        exp_gnt = PREEMPT ? 4'b0001 : 4'b0000;
        total++;
        if (gnt !== exp_gnt || gnt !== m_gnt) begin
            bad++;
            $display("FAIL preempt_edge gnt=%b expected %b", gnt, exp_gnt);
        end
        for (int c = 3; c <= 10; c++) begin
            tick();
            total++;
            if ({gnt, owner, busy, disp_data} !== {m_gnt, m_owner, (m_hold > 0), m_disp}) begin
                bad++;
                $display("FAIL preempt_cycle%0d gnt=%b owner=%0d busy=%b disp=%h expected %b/%0d/%b/%h",
                         c, gnt, owner, busy, disp_data, m_gnt, m_owner, (m_hold > 0), m_disp);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            req = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) wdata[32*i +: 32] = $urandom;
            tick();
            total++;
            if ({gnt, owner, busy, disp_data} !== {m_gnt, m_owner, (m_hold > 0), m_disp}) begin
                bad++;
                $display("FAIL random_cycle%0d gnt=%b owner=%0d busy=%b disp=%h expected %b/%0d/%b/%h",
                         c, gnt, owner, busy, disp_data, m_gnt, m_owner, (m_hold > 0), m_disp);
            end
        end
    endtask

    initial begin
        clr   = 1'b0;
        req   = '0;
        wdata = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_withdraw();
        test_reset_mid_hold();
        test_preempt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_bus_arbiter.md
DISPLAY_BUS_ARBITER -- requirements
Module: display_bus_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing the display bus.
REQ-002 The block SHALL have parameter DWELL, default 1000, giving the minimum number of cycles the granted value stays on the display; legal range 1..65535.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port clr, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port req, input, N_REQ bits: per-requester request, level.
REQ-006 Port wdata, input, N_REQ x 32 bits (packed, requester i at [32i+31:32i]): eight-nibble display word per requester.
REQ-007 Port gnt, output, N_REQ bits: one-hot, one-cycle grant pulse.
REQ-008 Port disp_data, output, 32 bits: registered word driving the seven-segment display data input.
REQ-009 Port owner, output, $clog2(N_REQ) bits: index of the last granted requester.
REQ-010 Port busy, output, 1 bit: high while the dwell interval is running.

Function
REQ-011 The FSM SHALL have two states: IDLE and HOLD.
REQ-012 In IDLE with req != 0 at a clock edge, the winner w SHALL be the first asserted req at or after index ptr, wrapping modulo N_REQ.
REQ-013 On that edge: gnt <= onehot(w); disp_data <= wdata[w]; owner <= w; ptr <= (w+1) mod N_REQ; cnt <= DWELL-1; state <= HOLD.
REQ-014 gnt SHALL be high for exactly the one cycle after the granting edge, then return to 0.
REQ-015 In IDLE with req == 0: no state change; gnt = 0; disp_data holds.
REQ-016 In HOLD: busy = 1; cnt decrements each cycle; at cnt == 0 the next state SHALL be IDLE; no grant is issued in HOLD.
REQ-017 The minimum spacing between consecutive gnt pulses SHALL be DWELL+1 cycles.
REQ-018 A requester SHALL keep req and wdata stable until it sees its gnt; dropping req before gnt withdraws the request with no side effect.
REQ-019 A req held high after its gnt SHALL be treated as a new request and compete under round-robin.
REQ-020 With N_REQ a non-power-of-two, pointer wrap SHALL skip unused indices.
REQ-021 disp_data SHALL change only on a granting edge or reset.

Reset
REQ-022 While clr = 0: state = IDLE, ptr = 0, cnt = 0, gnt = 0, disp_data = 32'h0, owner = 0, busy = 0, immediately and without waiting for clk.
REQ-023 Reset asserted mid-HOLD SHALL abort the dwell; the first grant after release follows REQ-012 from ptr = 0.

Configuration
REQ-024 Macro DISP_ARB_PREEMPT_EN SHALL enable preemption: in HOLD, if req[0] = 1 and owner != 0, requester 0 is granted on that edge per REQ-013 (ptr <= 1), restarting the dwell.
REQ-025 Without DISP_ARB_PREEMPT_EN, HOLD SHALL never be interrupted; requester 0 has no priority beyond round-robin.
REQ-026 With preemption, owner 0 SHALL NOT preempt itself.

Structure
REQ-027 Package disp_bus_pkg SHALL hold the state enum type, the default N_REQ and DWELL constants, and the 32-bit display word typedef.
REQ-028 Sub-module rr_picker (combinational: req and ptr in, one-hot winner and valid out) SHALL implement the round-robin search; the FSM, counter and registers stay in display_bus_arbiter.

Verification
REQ-029 Reset: clr = 0 with req = 4'b1111 -> gnt = 0, disp_data = 0, busy = 0; after release, the first grant goes to requester 0.
REQ-030 Round-robin: DWELL = 4, req = 4'b1111 held, wdata[i] = 32'h1111_1111*(i+1) -> gnt order 0,1,2,3,0, with pulses 5 cycles apart and disp_data tracking each winner.
REQ-031 Single requester: req = 4'b0100, wdata[2] = 32'hF000_F000 -> gnt = 4'b0100 on the next edge; disp_data = 32'hF000_F000; busy high for 4 cycles; re-grant after 5 cycles.
REQ-032 Withdrawal: req[1] raised in HOLD and dropped before HOLD ends, with no other req -> no gnt issued; disp_data unchanged.
REQ-033 Reset mid-HOLD: clr pulsed low at cnt = 2 -> busy = 0 and disp_data = 0 immediately; ptr restarts at 0.
REQ-034 Preempt (DISP_ARB_PREEMPT_EN defined): owner = 2 in HOLD, req[0] rises -> gnt = 4'b0001 on the next edge; without the macro, the grant waits until HOLD ends.
